// File: rtl/cxn_copy_buf_if.sv
// Packet handshake bundle for cxn_copy_buf: upstream Send/Ack with copy/branch tags,
// downstream Send/Ack with copy index, plus status (CP pulse, engine empty, occupancy).
interface cxn_copy_buf_if #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 2
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic              Send_in;
    logic              Ack_out;
    logic [DATA_W-1:0] Data_in;
    logic [CNT_W-1:0]  cpy;
    logic              exb;

    logic              Send_out;
    logic              Ack_in;
    logic [DATA_W-1:0] Data_out;
    logic [CNT_W-1:0]  Copy_idx;

    logic              CP;
    logic              feb;
    logic [OCC_W-1:0]  Count;

    // master: the environment around the block (producer + downstream consumer)
    modport master (
        output Send_in, Data_in, cpy, exb, Ack_in,
        input  Ack_out, Send_out, Data_out, Copy_idx, CP, feb, Count
    );

    modport slave (
        input  Send_in, Data_in, cpy, exb, Ack_in,
        output Ack_out, Send_out, Data_out, Copy_idx, CP, feb, Count
    );
endinterface

// File: rtl/cxn_copy_buf.sv
// Copy/branch stage: buffers tagged packets in a small FIFO, then emits each one
// 1+cpy times with a copy index, or drops it silently when its branch bit is clear.
module cxn_copy_buf #(
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 4,
    parameter int MAX_COPY = 3,
    parameter int CNT_W    = (MAX_COPY < 1) ? 1 : $clog2(MAX_COPY + 1)
) (
    input  logic          CLK,
    input  logic          MR,
    cxn_copy_buf_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [OCC_W-1:0] FULL_CNT  = OCC_W'(DEPTH);
    localparam logic [CNT_W-1:0] MAX_C     = CNT_W'(MAX_COPY);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    function automatic logic [CNT_W-1:0] clamp_cpy(input logic [CNT_W-1:0] c);
        return (c > MAX_C) ? MAX_C : c;
    endfunction

    // FIFO storage; contents need no reset, occupancy alone defines validity
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [CNT_W-1:0]  mem_cpy  [DEPTH];
    logic              mem_exb  [DEPTH];

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [OCC_W-1:0]  count;

    state_t            state;
    logic              send_out_r;
    logic [DATA_W-1:0] data_out_r;
    logic [CNT_W-1:0]  idx_r;
    logic [CNT_W-1:0]  held_cpy;
    logic              cp_r;
    logic              feb_r;

    logic full;
    logic empty;
    logic ack_out;
    logic push;
    logic xfer;
    logic last_xfer;
    logic pop;

    always_comb begin
        full      = (count == FULL_CNT);
        empty     = (count == '0);
        ack_out   = !full && !MR;
        push      = bus.Send_in && ack_out;
        xfer      = send_out_r && bus.Ack_in;
        last_xfer = xfer && (idx_r == held_cpy);
        // The engine frees up either when idle or on the final copy of its packet
        pop       = !empty && ((state == IDLE) || last_xfer);
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem_data[wr_ptr] <= bus.Data_in;
            mem_cpy[wr_ptr]  <= clamp_cpy(bus.cpy);
            mem_exb[wr_ptr]  <= bus.exb;
        end
    end

    always_ff @(posedge CLK) begin
        if (MR) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            state      <= IDLE;
            send_out_r <= 1'b0;
            data_out_r <= '0;
            idx_r      <= '0;
            held_cpy   <= '0;
            cp_r       <= 1'b0;
            feb_r      <= 1'b1;
        end else begin
            cp_r <= pop;

            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end

            case ({push, pop})
                2'b10:   count <= count + OCC_W'(1);
                2'b01:   count <= count - OCC_W'(1);
                default: count <= count;
            endcase

            if (pop) begin
                if (mem_exb[rd_ptr]) begin
                    state      <= EMIT;
                    send_out_r <= 1'b1;
                    feb_r      <= 1'b0;
                    data_out_r <= mem_data[rd_ptr];
                    held_cpy   <= mem_cpy[rd_ptr];
                    idx_r      <= '0;
                end else begin
                    // Discarded packet: output registers keep their last values
                    state      <= IDLE;
                    send_out_r <= 1'b0;
                    feb_r      <= 1'b1;
                end
            end else if ((state == EMIT) && xfer) begin
                if (last_xfer) begin
                    state      <= IDLE;
                    send_out_r <= 1'b0;
                    feb_r      <= 1'b1;
                end else begin
                    idx_r <= idx_r + CNT_W'(1);
                end
            end
        end
    end

    assign bus.Ack_out  = ack_out;
    assign bus.Send_out = send_out_r;
    assign bus.Data_out = data_out_r;
    assign bus.Copy_idx = idx_r;
    assign bus.CP       = cp_r;
    assign bus.feb      = feb_r;
    assign bus.Count    = count;

endmodule

// File: tb/tb_cxn_copy_buf.sv
// Directed bench for cxn_copy_buf: two instances (MAX_COPY=3 and MAX_COPY=2) share
// one stimulus stream so the copy clamp can be observed side by side.
module tb_cxn_copy_buf;
    logic        clk = 1'b0;
    logic        mr;
    logic        send_in;
    logic [15:0] data_in;
    logic [1:0]  cpy_in;
    logic        exb_in;
    logic        ack_in;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cxn_copy_buf_if #(.DATA_W(16), .DEPTH(4), .CNT_W(2)) ifa ();
    cxn_copy_buf_if #(.DATA_W(16), .DEPTH(4), .CNT_W(2)) ifb ();

    assign ifa.Send_in = send_in;
    assign ifa.Data_in = data_in;
    assign ifa.cpy     = cpy_in;
    assign ifa.exb     = exb_in;
    assign ifa.Ack_in  = ack_in;
    assign ifb.Send_in = send_in;
    assign ifb.Data_in = data_in;
    assign ifb.cpy     = cpy_in;
    assign ifb.exb     = exb_in;
    assign ifb.Ack_in  = ack_in;

    cxn_copy_buf #(.DATA_W(16), .DEPTH(4), .MAX_COPY(3)) dut_a (
        .CLK (clk),
        .MR  (mr),
        .bus (ifa)
    );

    cxn_copy_buf #(.DATA_W(16), .DEPTH(4), .MAX_COPY(2)) dut_b (
        .CLK (clk),
        .MR  (mr),
        .bus (ifb)
    );

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic emit_a(input string tag, input logic [15:0] d, input logic [1:0] idx);
        chk_val({tag, "_send"}, 32'(ifa.Send_out), 32'd1);
        chk_val({tag, "_data"}, 32'(ifa.Data_out), 32'(d));
        chk_val({tag, "_idx"},  32'(ifa.Copy_idx), 32'(idx));
    endtask

    logic [15:0] exp_d  [7] = '{16'h1000, 16'h1001, 16'h1001, 16'h1002, 16'h1003, 16'h1003, 16'h1004};
    logic [1:0]  exp_i  [7] = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd1, 2'd0};
    logic        exp_cp [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        mr      = 1'b1;
        send_in = 1'b0;
        data_in = '0;
        cpy_in  = '0;
        exb_in  = 1'b0;
        ack_in  = 1'b0;

        // ---- reset / idle
        step();
        step();
        chk_val("rst_ack",   32'(ifa.Ack_out),  32'd0);
        chk_val("rst_send",  32'(ifa.Send_out), 32'd0);
        chk_val("rst_feb",   32'(ifa.feb),      32'd1);
        chk_val("rst_count", 32'(ifa.Count),    32'd0);
        chk_val("rst_cp",    32'(ifa.CP),       32'd0);
        chk_val("rst_data",  32'(ifa.Data_out), 32'd0);
        chk_val("rst_idx",   32'(ifa.Copy_idx), 32'd0);
        mr = 1'b0;
        #1;
        chk_val("post_rst_ack", 32'(ifa.Ack_out), 32'd1);

        // ---- copy fan-out: 0x1234, cpy=2
        send_in = 1'b1; data_in = 16'h1234; cpy_in = 2'd2; exb_in = 1'b1; ack_in = 1'b1;
        step();
        send_in = 1'b0;
        chk_val("fan_cnt1", 32'(ifa.Count),    32'd1);
        chk_val("fan_s0",   32'(ifa.Send_out), 32'd0);
        step();
        emit_a("fan_e0", 16'h1234, 2'd0);
        chk_val("fan_cp",   32'(ifa.CP),    32'd1);
        chk_val("fan_feb0", 32'(ifa.feb),   32'd0);
        chk_val("fan_cnt0", 32'(ifa.Count), 32'd0);
        step();
        emit_a("fan_e1", 16'h1234, 2'd1);
        chk_val("fan_cp1", 32'(ifa.CP), 32'd0);
        step();
        emit_a("fan_e2", 16'h1234, 2'd2);
        chk_val("fan_cp2", 32'(ifa.CP), 32'd0);
        step();
        chk_val("fan_end_send", 32'(ifa.Send_out), 32'd0);
        chk_val("fan_end_feb",  32'(ifa.feb),      32'd1);
        chk_val("fan_end_cp",   32'(ifa.CP),       32'd0);

        // ---- discard 0xAAAA, then 0xBBBB cpy=3 (B clamps to 2)
        send_in = 1'b1; data_in = 16'hAAAA; cpy_in = 2'd0; exb_in = 1'b0;
        step();
        data_in = 16'hBBBB; cpy_in = 2'd3; exb_in = 1'b1;
        step();
        send_in = 1'b0;
        chk_val("disc_cp_a",   32'(ifa.CP),       32'd1);
        chk_val("disc_cp_b",   32'(ifb.CP),       32'd1);
        chk_val("disc_send_a", 32'(ifa.Send_out), 32'd0);
        chk_val("disc_send_b", 32'(ifb.Send_out), 32'd0);
        chk_val("disc_data_a", 32'(ifa.Data_out), 32'h1234);
        chk_val("disc_cnt_a",  32'(ifa.Count),    32'd1);
        for (int k = 0; k < 3; k++) begin
            step();
            emit_a("bb_a", 16'hBBBB, 2'(k));
            chk_val("bb_b_send", 32'(ifb.Send_out), 32'd1);
            chk_val("bb_b_data", 32'(ifb.Data_out), 32'hBBBB);
            chk_val("bb_b_idx",  32'(ifb.Copy_idx), 32'(k));
            chk_val("bb_cp_b",   32'(ifb.CP),       (k == 0) ? 32'd1 : 32'd0);
        end
        step();
        emit_a("bb_a3", 16'hBBBB, 2'd3);
        chk_val("bb_b_done_send", 32'(ifb.Send_out), 32'd0);
        chk_val("bb_b_done_feb",  32'(ifb.feb),      32'd1);
        chk_val("bb_b_hold_idx",  32'(ifb.Copy_idx), 32'd2);
        step();
        chk_val("bb_a_done_send", 32'(ifa.Send_out), 32'd0);
        chk_val("bb_a_done_feb",  32'(ifa.feb),      32'd1);

        // ---- 0xCCCC cpy=3 on the MAX_COPY=3 instance: four emissions
        send_in = 1'b1; data_in = 16'hCCCC; cpy_in = 2'd3; exb_in = 1'b1;
        step();
        send_in = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            emit_a("cc", 16'hCCCC, 2'(k));
        end
        step();
        chk_val("cc_done_send", 32'(ifa.Send_out), 32'd0);

        // ---- backpressure: fill engine + FIFO, hold, then drain
        ack_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send_in = 1'b1; data_in = 16'h1000 + 16'(i); cpy_in = 2'(i % 2); exb_in = 1'b1;
            chk_val("bp_ack_open", 32'(ifa.Ack_out), 32'd1);
            step();
        end
        send_in = 1'b0;
        chk_val("bp_full_cnt", 32'(ifa.Count),   32'd4);
        chk_val("bp_full_ack", 32'(ifa.Ack_out), 32'd0);
        for (int k = 0; k < 5; k++) begin
            emit_a("bp_hold", 16'h1000, 2'd0);
            chk_val("bp_hold_cnt", 32'(ifa.Count), 32'd4);
            step();
        end
        ack_in = 1'b1;
        for (int k = 0; k < 7; k++) begin
            emit_a("bp_drain", exp_d[k], exp_i[k]);
            chk_val("bp_drain_cp", 32'(ifa.CP),       32'(exp_cp[k]));
            chk_val("bp_drain_b",  32'(ifb.Data_out), 32'(exp_d[k]));
            step();
        end
        chk_val("bp_end_send", 32'(ifa.Send_out), 32'd0);
        chk_val("bp_end_feb",  32'(ifa.feb),      32'd1);
        chk_val("bp_end_cnt",  32'(ifa.Count),    32'd0);

        // ---- reset in the middle of an emission with two packets buffered
        send_in = 1'b1; data_in = 16'h5000; cpy_in = 2'd3; exb_in = 1'b1;
        step();
        data_in = 16'h5001; cpy_in = 2'd0;
        step();
        data_in = 16'h5002;
        step();
        send_in = 1'b0;
        emit_a("mr_pre", 16'h5000, 2'd1);
        chk_val("mr_pre_cnt", 32'(ifa.Count), 32'd2);
        mr = 1'b1;
        #1;
        chk_val("mr_ack", 32'(ifa.Ack_out), 32'd0);
        step();
        chk_val("mr_send", 32'(ifa.Send_out), 32'd0);
        chk_val("mr_cnt",  32'(ifa.Count),    32'd0);
        chk_val("mr_feb",  32'(ifa.feb),      32'd1);
        chk_val("mr_idx",  32'(ifa.Copy_idx), 32'd0);
        chk_val("mr_data", 32'(ifa.Data_out), 32'd0);
        mr = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk_val("mr_quiet_send", 32'(ifa.Send_out), 32'd0);
            chk_val("mr_quiet_cnt",  32'(ifa.Count),    32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
